// File: rtl/div64by32.sv
// Sequential restoring divider: 64-bit dividend / 32-bit divisor, one quotient bit per clock.
// Optional macro DIV64_DBZ_FLAG_EN adds the dbz port and a short divide-by-zero path.
module div64by32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [63:0] quotient,
`ifdef DIV64_DBZ_FLAG_EN
  output logic [31:0] remainder,
  output logic        dbz
`else
  output logic [31:0] remainder
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] d_q;
  logic [31:0] p_q;
  logic [31:0] dvsr_q;
  logic [5:0]  cnt_q;

  logic [32:0] p_shift;
  logic [31:0] p_diff;
  logic [31:0] p_next;
  logic [63:0] d_next;
  logic        ge;
  logic        dbz_fast;
  logic        finish;

  // Partial remainder is stored as 32 bits: bit 32 of P' only matters for the compare
  // and never feeds back, since only P'[31:0] is shifted into the next iteration.
  assign p_shift = {p_q, d_q[63]};
  assign ge      = p_shift >= {1'b0, dvsr_q};
  assign p_diff  = p_shift[31:0] - dvsr_q;
  assign p_next  = ge ? p_diff : p_shift[31:0];
  assign d_next  = {d_q[62:0], ge};

`ifdef DIV64_DBZ_FLAG_EN
  assign dbz_fast = (dvsr_q == 32'd0);
`else
  assign dbz_fast = 1'b0;
`endif

  assign finish = (cnt_q == 6'd63) || dbz_fast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (finish) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q       <= '0;
      p_q       <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV64_DBZ_FLAG_EN
      dbz       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            d_q    <= dividend;
            dvsr_q <= divisor;
            p_q    <= '0;
            cnt_q  <= '0;
`ifdef DIV64_DBZ_FLAG_EN
            dbz    <= 1'b0;
`endif
          end
        end
        StRun: begin
          d_q   <= d_next;
          p_q   <= p_next;
          cnt_q <= cnt_q + 6'd1;
          if (finish) begin
            // Zero divisor short path: d_q still holds the untouched dividend here.
            if (dbz_fast) begin
              quotient  <= '1;
              remainder <= d_q[31:0];
            end else begin
              quotient  <= d_next;
              remainder <= p_next;
            end
`ifdef DIV64_DBZ_FLAG_EN
            dbz <= dbz_fast;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div64by32.sv
// Self-checking bench for div64by32: directed cases, handshake corner cases and random
// round trips against plain 64-bit division.
module tb_div64by32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [31:0] remainder;
`ifdef DIV64_DBZ_FLAG_EN
  logic        dbz;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int overlap  = 0;

  div64by32 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
`ifdef DIV64_DBZ_FLAG_EN
    .remainder (remainder),
    .dbz       (dbz)
`else
    .remainder (remainder)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
  always @(negedge clk) if (busy && done) overlap <= overlap + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for done and check timing and results against plain division.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b);
    logic [63:0] eq;
    logic [31:0] er;
    int lat, bsy, exp_lat;
    if (b == 32'd0) begin
      eq = '1;
      er = a[31:0];
    end else begin
      eq = a / {32'd0, b};
      er = 32'(a % {32'd0, b});
    end
    exp_lat = 64;
`ifdef DIV64_DBZ_FLAG_EN
    if (b == 32'd0) exp_lat = 1;
`endif
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = {$urandom, $urandom}; divisor = $urandom;
    lat = 0; bsy = 0;
    while (!done && lat < 100) begin
      if (busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(bsy), 64'(exp_lat));
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, {32'd0, remainder}, {32'd0, er});
`ifdef DIV64_DBZ_FLAG_EN
    chk({tag, "_dbz"}, {63'd0, dbz}, {63'd0, (b == 32'd0)});
`endif
    @(posedge clk); #1;
    chk({tag, "_done_pulse_end"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat, dc;
    logic [31:0] ra, rb;
    logic [63:0] rd;

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", {32'd0, remainder}, 64'd0);
`ifdef DIV64_DBZ_FLAG_EN
    chk("reset_dbz", {63'd0, dbz}, 64'd0);
`endif
    @(negedge clk); reset = 1'b0;

    run_op("d100_7", 64'd100, 32'd7);
    run_op("allones", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_one", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1);
    run_op("div_zero", 64'h1234_5678_9ABC_DEF0, 32'd0);
    run_op("after_zero", 64'd12345, 32'd5);

    // start during RUN and during DONE must be ignored
    dc = done_cnt;
    @(negedge clk); start = 1'b1; dividend = 64'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); start = 1'b1; dividend = 64'd999; divisor = 32'd3;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_done_seen", {63'd0, done}, 64'd1);
    @(negedge clk); start = 1'b1; dividend = 64'd50; divisor = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    chk("ign_start_in_done", {63'd0, busy}, 64'd0);
    repeat (70) @(posedge clk);
    #1;
    chk("ign_single_done", 64'(done_cnt - dc), 64'd1);
    chk("ign_quotient", quotient, 64'd14);
    chk("ign_remainder", {32'd0, remainder}, 64'd2);

    // reset at E30 aborts silently
    @(negedge clk); start = 1'b1; dividend = 64'hDEAD_BEEF_0000_1111; divisor = 32'd77;
    @(posedge clk); #1; start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    @(negedge clk); reset = 1'b0;
    dc = done_cnt;
    repeat (70) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(done_cnt - dc), 64'd0);
    run_op("d1000_10", 64'd1000, 32'd10);

    // Round trip through the 32x32 product
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      run_op("roundtrip", {32'd0, ra} * {32'd0, rb}, rb);
    end

    for (int i = 0; i < 100; i++) begin
      rd = {$urandom, $urandom};
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = rb & 32'h0000_00FF;
        1: rb = rb & 32'h0000_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 31) == 0) rb = 32'd0;
      run_op("random", rd, rb);
    end

    chk("busy_done_overlap", 64'(overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
